// File: rtl/hazard_ctrl.sv
// Hazard, stall and forwarding controller: stall FSM for load-use bubbles, data-cache waits
// and halt, EX operand forwarding selects, and stall/flush performance counters.
module hazard_ctrl #(
   parameter int unsigned REGW     = 5,
   parameter int unsigned NFWD     = 2,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNTW     = 32,
   parameter int unsigned FSELW    = $clog2(NFWD + 1)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   ihit,
   input  logic                   dhit,
   input  logic                   mem_req,
   input  logic                   br_taken,
   input  logic                   halt,
   input  logic [REGW-1:0]        id_rs,
   input  logic [REGW-1:0]        id_rt,
   input  logic [REGW-1:0]        idex_dst,
   input  logic                   idex_wen,
   input  logic                   idex_ld,
   input  logic [REGW-1:0]        ex_rs,
   input  logic [REGW-1:0]        ex_rt,
   input  logic [NFWD*REGW-1:0]   dst_vec,
   input  logic [NFWD-1:0]        wen_vec,
   output logic                   pc_stall,
   output logic [3:0]             stall,
   output logic [3:0]             flush,
   output logic [FSELW-1:0]       fwd_a,
   output logic [FSELW-1:0]       fwd_b,
   output logic [CNTW-1:0]        stall_cnt,
   output logic [CNTW-1:0]        flush_cnt
);

   // Counter only ever holds LOAD_LAT-1 down to 1.
   localparam int unsigned LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

   typedef enum logic [1:0] {StRun, StLdStall, StDWait, StHalted} state_e;

   state_e           state_q, state_d;
   logic [LCW-1:0]   lat_q, lat_d;
   logic             ret_ld_q, ret_ld_d;
   logic [CNTW-1:0]  stall_cnt_q, flush_cnt_q;
   logic             luh, dmiss;

   assign luh   = idex_ld & idex_wen & (idex_dst != '0) &
                  ((idex_dst == id_rs) | (idex_dst == id_rt));
   assign dmiss = mem_req & ~dhit;

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      ret_ld_d = ret_ld_q;
      pc_stall = 1'b0;
      stall    = 4'b0000;
      flush    = 4'b0000;
      if (RST) begin
         pc_stall = 1'b1;
         flush    = 4'b1111;
      end else begin
         unique case (state_q)
            StRun: begin
               if (halt) begin
                  pc_stall = 1'b1;
                  stall    = 4'b1111;
                  state_d  = StHalted;
               end else if (dmiss) begin
                  pc_stall = 1'b1;
                  stall    = 4'b1111;
                  ret_ld_d = 1'b0;
                  state_d  = StDWait;
               end else if (br_taken) begin
                  flush = 4'b0011;
               end else if (luh) begin
                  pc_stall = 1'b1;
                  stall    = 4'b0001;
                  flush    = 4'b0010;
                  lat_d    = LCW'(LOAD_LAT - 1);
                  if (LOAD_LAT > 1) state_d = StLdStall;
               end else if (!ihit) begin
                  pc_stall = 1'b1;
                  flush    = 4'b0001;
               end
            end
            StLdStall: begin
               if (dmiss) begin
                  // Freeze the bubble; the counter resumes after the cache wait.
                  pc_stall = 1'b1;
                  stall    = 4'b1111;
                  ret_ld_d = 1'b1;
                  state_d  = StDWait;
               end else if (br_taken) begin
                  flush   = 4'b0011;
                  state_d = StRun;
               end else begin
                  pc_stall = 1'b1;
                  stall    = 4'b0001;
                  flush    = 4'b0010;
                  lat_d    = lat_q - LCW'(1);
                  if (lat_q == LCW'(1)) state_d = StRun;
               end
            end
            StDWait: begin
               if (dhit) begin
                  state_d = ret_ld_q ? StLdStall : StRun;
               end else begin
                  pc_stall = 1'b1;
                  stall    = 4'b1111;
               end
            end
            StHalted: begin
               pc_stall = 1'b1;
               stall    = 4'b1111;
            end
            default: state_d = StRun;
         endcase
      end
   end

   // Descending scan so the lowest-numbered matching producer wins.
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      for (int k = NFWD - 1; k >= 0; k--) begin
         if (wen_vec[k] && (dst_vec[k*REGW +: REGW] != '0)) begin
            if (dst_vec[k*REGW +: REGW] == ex_rs) fwd_a = FSELW'(k + 1);
            if (dst_vec[k*REGW +: REGW] == ex_rt) fwd_b = FSELW'(k + 1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StRun;
         lat_q       <= '0;
         ret_ld_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         ret_ld_q <= ret_ld_d;
         if (pc_stall && (state_q != StHalted)) stall_cnt_q <= stall_cnt_q + CNTW'(1);
         if (flush[1]) flush_cnt_q <= flush_cnt_q + CNTW'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random stimulus against a
// cycle-level behavioural model of the pipeline-control rules.
module tb_hazard_ctrl;

   localparam int unsigned REGW     = 5;
   localparam int unsigned NFWD     = 2;
   localparam int unsigned LOAD_LAT = 2;
   localparam int unsigned CNTW     = 4;
   localparam int unsigned FSELW    = 2;

   logic                 clk = 1'b0;
   logic                 rst, ihit, dhit, mem_req, br_taken, halt;
   logic [REGW-1:0]      id_rs, id_rt, idex_dst, ex_rs, ex_rt;
   logic                 idex_wen, idex_ld;
   logic [NFWD*REGW-1:0] dst_vec;
   logic [NFWD-1:0]      wen_vec;
   logic                 pc_stall;
   logic [3:0]           stall, flush;
   logic [FSELW-1:0]     fwd_a, fwd_b;
   logic [CNTW-1:0]      stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: halted / waiting on dcache / remaining load bubble cycles after the first.
   bit m_halt, m_wait;
   int m_bub, m_sc, m_fc;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .REGW(REGW), .NFWD(NFWD), .LOAD_LAT(LOAD_LAT), .CNTW(CNTW), .FSELW(FSELW)
   ) dut (
      .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
      .br_taken(br_taken), .halt(halt), .id_rs(id_rs), .id_rt(id_rt),
      .idex_dst(idex_dst), .idex_wen(idex_wen), .idex_ld(idex_ld),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .dst_vec(dst_vec), .wen_vec(wen_vec),
      .pc_stall(pc_stall), .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int fwd_model(input logic [REGW-1:0] src);
      for (int k = 0; k < NFWD; k++) begin
         logic [REGW-1:0] d;
         d = dst_vec[k*REGW +: REGW];
         if (wen_vec[k] && d != 0 && d == src) return k + 1;
      end
      return 0;
   endfunction

   task automatic set_idle();
      rst = 1'b0; ihit = 1'b1; dhit = 1'b1; mem_req = 1'b0; br_taken = 1'b0; halt = 1'b0;
      id_rs = '0; id_rt = '0; idex_dst = '0; idex_wen = 1'b0; idex_ld = 1'b0;
      ex_rs = '0; ex_rt = '0; dst_vec = '0; wen_vec = '0;
   endtask

   // Check the current cycle against the model, advance the model, move to the next negedge.
   task automatic tick();
      logic       e_pc;
      logic [3:0] e_st, e_fl;
      bit         luh, n_halt, n_wait;
      int         n_bub;
      #1;
      e_pc = 1'b0; e_st = 4'h0; e_fl = 4'h0;
      n_halt = m_halt; n_wait = m_wait; n_bub = m_bub;
      luh = idex_ld && idex_wen && idex_dst != 0 && (idex_dst == id_rs || idex_dst == id_rt);
      if (rst) begin
         e_pc = 1'b1; e_fl = 4'hF; n_halt = 0; n_wait = 0; n_bub = 0;
      end else if (m_halt) begin
         e_pc = 1'b1; e_st = 4'hF;
      end else if (m_wait) begin
         if (dhit) n_wait = 0;
         else begin e_pc = 1'b1; e_st = 4'hF; end
      end else if (m_bub == 0 && halt) begin
         e_pc = 1'b1; e_st = 4'hF; n_halt = 1;
      end else if (mem_req && !dhit) begin
         e_pc = 1'b1; e_st = 4'hF; n_wait = 1;
      end else if (br_taken) begin
         e_fl = 4'h3; n_bub = 0;
      end else if (m_bub > 0) begin
         e_pc = 1'b1; e_st = 4'h1; e_fl = 4'h2; n_bub = m_bub - 1;
      end else if (luh) begin
         e_pc = 1'b1; e_st = 4'h1; e_fl = 4'h2; n_bub = LOAD_LAT - 1;
      end else if (!ihit) begin
         e_pc = 1'b1; e_fl = 4'h1;
      end
      check_eq("pc_stall", 32'(pc_stall), 32'(e_pc));
      check_eq("stall", 32'(stall), 32'(e_st));
      check_eq("flush", 32'(flush), 32'(e_fl));
      check_eq("fwd_a", 32'(fwd_a), 32'(fwd_model(ex_rs)));
      check_eq("fwd_b", 32'(fwd_b), 32'(fwd_model(ex_rt)));
      check_eq("stall_cnt", 32'(stall_cnt), 32'(m_sc));
      check_eq("flush_cnt", 32'(flush_cnt), 32'(m_fc));
      if (rst) begin
         m_sc = 0; m_fc = 0;
      end else begin
         if (e_pc && !m_halt) m_sc = (m_sc + 1) % (1 << CNTW);
         if (e_fl[1]) m_fc = (m_fc + 1) % (1 << CNTW);
      end
      m_halt = n_halt; m_wait = n_wait; m_bub = n_bub;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      m_halt = 0; m_wait = 0; m_bub = 0; m_sc = 0; m_fc = 0;
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_eq("rst_pc_stall", 32'(pc_stall), 32'h1);
      check_eq("rst_stall", 32'(stall), 32'h0);
      check_eq("rst_flush", 32'(flush), 32'hF);
      tick();
      rst = 1'b0;

      // Forwarding priority
      ex_rs = 5'd5; dst_vec = {5'd5, 5'd5}; wen_vec = 2'b11;
      #1 check_eq("fwd_lowest", 32'(fwd_a), 32'h1);
      tick();
      wen_vec = 2'b10;
      #1 check_eq("fwd_second", 32'(fwd_a), 32'h2);
      tick();
      ex_rs = 5'd0; dst_vec = '0; wen_vec = 2'b11;
      #1 check_eq("fwd_r0", 32'(fwd_a), 32'h0);
      tick();

      // Load-use bubble of LOAD_LAT cycles
      set_idle();
      idex_ld = 1'b1; idex_wen = 1'b1; idex_dst = 5'd8; id_rt = 5'd8;
      #1 check_eq("luh_pc1", 32'(pc_stall), 32'h1);
      tick();
      idex_ld = 1'b0;
      #1 check_eq("luh_pc2", 32'(pc_stall), 32'h1);
      tick();
      #1 check_eq("luh_done", 32'({pc_stall, stall, flush}), 32'h0);
      check_eq("luh_stall_cnt", 32'(stall_cnt), 32'h2);
      tick();

      // Data-cache wait
      do_reset();
      set_idle();
      mem_req = 1'b1; dhit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 check_eq("dwait_stall", 32'(stall), 32'hF);
         tick();
      end
      dhit = 1'b1;
      #1 check_eq("dwait_exit", 32'({pc_stall, stall}), 32'h0);
      tick();
      mem_req = 1'b0;
      #1 check_eq("dwait_stall_cnt", 32'(stall_cnt), 32'h3);
      tick();

      // Branch beats load-use
      do_reset();
      set_idle();
      br_taken = 1'b1; idex_ld = 1'b1; idex_wen = 1'b1; idex_dst = 5'd3; id_rs = 5'd3;
      #1 check_eq("br_flush", 32'(flush), 32'h3);
      check_eq("br_pc", 32'(pc_stall), 32'h0);
      tick();
      set_idle();
      #1 check_eq("br_flush_cnt", 32'(flush_cnt), 32'h1);
      check_eq("br_no_ldstall", 32'(pc_stall), 32'h0);
      tick();

      // Halt is sticky until reset
      halt = 1'b1;
      tick();
      halt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 check_eq("halt_sticky", 32'(stall), 32'hF);
         tick();
      end
      do_reset();
      set_idle();
      #1 check_eq("halt_rst_cnt", 32'({stall_cnt, flush_cnt}), 32'h0);
      check_eq("halt_rst_run", 32'(stall), 32'h0);
      tick();

      // Counter wrap at 2^CNTW
      do_reset();
      set_idle();
      ihit = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      ihit = 1'b1;
      #1 check_eq("stall_cnt_wrap", 32'(stall_cnt), 32'h0);
      tick();

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         rst      = ($urandom_range(99) == 0);
         halt     = ($urandom_range(59) == 0);
         mem_req  = ($urandom_range(2) == 0);
         dhit     = $urandom_range(1) == 1;
         br_taken = ($urandom_range(7) == 0);
         ihit     = ($urandom_range(3) != 0);
         idex_ld  = $urandom_range(1) == 1;
         idex_wen = ($urandom_range(3) != 0);
         idex_dst = 5'($urandom_range(3));
         id_rs    = 5'($urandom_range(3));
         id_rt    = 5'($urandom_range(3));
         ex_rs    = 5'($urandom_range(3));
         ex_rt    = 5'($urandom_range(3));
         dst_vec  = {5'($urandom_range(3)), 5'($urandom_range(3))};
         wen_vec  = 2'($urandom_range(3));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
